hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage MIPS core. It is the consumer side of the packed inter-stage buses. It watches the ID/EX and EX/MEM pipeline words plus the decoded ID-stage register fields, and drives the hold, bubble and flush controls back into the PC and the pipeline registers. It owns load-use stalls, branch flushes, data-memory wait freezes, a wait timeout, and saturating hazard statistics counters.

Parameters:
CNT_W, 16, width of the stall and flush statistics counters (saturating)
MAX_WAIT, 8, maximum consecutive MEM_WAIT cycles before the timeout error is raised

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_rs  input  5  rs field of the instruction in ID
id_rt  input  5  rt field of the instruction in ID
id_uses_rt  input  1  instruction in ID reads rt as a source
id_ex_bus  input  159  ID/EX word: [155]=MemRead, [9:5]=rt
ex_mem_bus  input  111  EX/MEM word: [109]=MemRead, [108]=MemWrite, [106]=Branch
mem_taken  input  1  branch condition resolved true in MEM
dmem_busy  input  1  data memory not ready this cycle
pc_write  output  1  1 = PC updates
if_id_hold  output  1  1 = IF/ID keeps its value (IF/ID write-hold polarity)
id_ex_hold  output  1  1 = ID/EX keeps its value
ex_mem_hold  output  1  1 = EX/MEM keeps its value
id_ex_bubble  output  1  1 = zero the control bits [158:143] loaded into ID/EX
mem_wb_bubble  output  1  1 = zero RegWrite/MentoReg loaded into MEM/WB
flush_if_id  output  1  1 = IF/ID loads a NOP
flush_id_ex  output  1  1 = ID/EX loads a bubble
ex_mem_bubble  output  1  1 = zero control bits [110:101] loaded into EX/MEM
state  output  2  FSM state: RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3
stall_cnt  output  CNT_W  count of stall cycles (load-use plus mem wait)
flush_cnt  output  CNT_W  count of branch flush events
mem_timeout  output  1  sticky error flag

Behaviour:
- Reset (asynchronous, rst_n=0): state=RUN, both counters=0, mem_timeout=0, wait counter=0.
- Outputs while in reset: pc_write=1; every hold, bubble and flush output = 0.
- Hazard terms (combinational, evaluated every cycle):
  - flush_req = ex_mem_bus[106] & mem_taken.
  - wait_req = dmem_busy & (ex_mem_bus[109] | ex_mem_bus[108]).
  - lu_req = id_ex_bus[155] & (rt_x != 0) & ((rt_x == id_rs) | (id_uses_rt & rt_x == id_rt)), where rt_x = id_ex_bus[9:5].
- Priority is flush > wait > load-use. Outputs are Mealy, decided in the same cycle.
- Default when no term is active: pc_write=1; all other controls 0.
- flush_req:
  - Assert flush_if_id, flush_id_ex and ex_mem_bubble.
  - pc_write=1, since the PC loads the branch target.
  - Next state=FLUSH; flush_cnt increments.
- wait_req (no flush):
  - pc_write=0; if_id_hold, id_ex_hold, ex_mem_hold and mem_wb_bubble all = 1.
  - Next state=MEM_WAIT; stall_cnt increments.
- lu_req (no flush, no wait):
  - pc_write=0, if_id_hold=1, id_ex_bubble=1.
  - Next state=LOAD_STALL; stall_cnt increments.
- LOAD_STALL lasts exactly one cycle, then the next state is recomputed by priority. lu_req cannot fire here because the bubble has cleared MemRead.
- FLUSH lasts one cycle. lu_req is ignored in FLUSH because the ID contents are being discarded. flush_req and wait_req are still honoured.
- MEM_WAIT:
  - Stays while wait_req holds. The wait counter increments each cycle and resets on exit.
  - If the counter reaches MAX_WAIT, mem_timeout is set. It stays set until reset.
  - Counting continues past the timeout; the freeze is not broken.
  - A flush_req while in MEM_WAIT is impossible because EX/MEM is frozen; no special handling.
- Both counters saturate at all ones and never wrap.
- Reset asserted mid-stall returns immediately to RUN with outputs at default.

Test Plan:
- Load-use stall: ID/EX MemRead=1, rt=5; id_rs=5 in ID.
  - Required: one cycle with pc_write=0, if_id_hold=1, id_ex_bubble=1; state 0->1->0; stall_cnt=1.
- rt=0 and non-use cases: load with rt=0 and id_rs=0 gives no stall. Load with rt=7, id_rt=7 and id_uses_rt=0 also gives no stall.
- Branch flush: ex_mem_bus[106]=1 and mem_taken=1.
  - Required: flush_if_id, flush_id_ex and ex_mem_bubble all 1 for one cycle; pc_write=1; flush_cnt=1.
  - A simultaneous lu_req is suppressed in the following FLUSH cycle.
- Memory wait: MemWrite=1 with dmem_busy held for 3 cycles.
  - Required: 3 frozen cycles with all holds=1 and pc_write=0; stall_cnt=3; state returns to RUN on the 4th cycle.
- Timeout: dmem_busy held for 10 cycles with MAX_WAIT=8.
  - Required: mem_timeout rises after the 8th wait cycle and stays 1 after the wait ends, until rst_n pulses low.
- Saturation and reset: CNT_W=2, five load-use stalls gives stall_cnt=3. Asserting rst_n=0 during MEM_WAIT gives state=0, counters=0 and pc_write=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Hazard and stall controller for the 5-stage MIPS pipeline. It watches the
// ID/EX and EX/MEM pipeline words and the decoded ID register fields, and
// drives the hold, bubble and flush controls back into the PC and the
// pipeline registers.
// Ports:
//   clk, rst_n        pipeline clock, asynchronous active-low reset
//   id_rs, id_rt      source register fields of the instruction in ID
//   id_uses_rt        the ID instruction reads rt as a source
//   id_ex_bus         ID/EX word ([155]=MemRead, [9:5]=rt)
//   ex_mem_bus        EX/MEM word ([109]=MemRead, [108]=MemWrite, [106]=Branch)
//   mem_taken         branch condition resolved true in MEM
//   dmem_busy         data memory not ready this cycle
//   pc_write .. ex_mem_bubble  pipeline controls (Mealy, same-cycle)
//   state             FSM state: RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3
//   stall_cnt         saturating count of stall cycles
//   flush_cnt         saturating count of branch flushes
//   mem_timeout       sticky flag: MAX_WAIT consecutive memory-wait cycles
module hazard_stall_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [158:0]     id_ex_bus,
  input  logic [110:0]     ex_mem_bus,
  input  logic             mem_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             if_id_hold,
  output logic             id_ex_hold,
  output logic             ex_mem_hold,
  output logic             id_ex_bubble,
  output logic             mem_wb_bubble,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             ex_mem_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  localparam int                WCNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_ONE  = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WAIT_SAT  = WCNT_W'(MAX_WAIT);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t            state_r;
  state_t            next_state;
  logic [WCNT_W-1:0] wait_cnt;
  logic [4:0]        rt_x;
  logic              flush_req;
  logic              wait_req;
  logic              lu_raw;
  logic              wait_go;
  logic              lu_go;
  logic              unused_bus_bits;

  // Only a handful of bus fields matter here; fold the rest away.
  assign unused_bus_bits = ^{id_ex_bus[158:156], id_ex_bus[154:10], id_ex_bus[4:0],
                             ex_mem_bus[110], ex_mem_bus[107], ex_mem_bus[105:0]};

  assign rt_x      = id_ex_bus[9:5];
  assign flush_req = ex_mem_bus[106] & mem_taken;
  assign wait_req  = dmem_busy & (ex_mem_bus[109] | ex_mem_bus[108]);
  assign lu_raw    = id_ex_bus[155] & (rt_x != 5'd0) &
                     ((rt_x == id_rs) | (id_uses_rt & (rt_x == id_rt)));

  // Load-use is ignored in FLUSH (ID is being discarded) and in LOAD_STALL
  // (the stall lasts exactly one cycle; the bubble already cleared MemRead).
  assign wait_go = wait_req & ~flush_req;
  assign lu_go   = lu_raw & ~flush_req & ~wait_req &
                   (state_r != LOAD_STALL) & (state_r != FLUSH);

  assign state = state_r;

  // Mealy pipeline controls, forced to the run defaults while in reset.
  always_comb begin
    pc_write      = 1'b1;
    if_id_hold    = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_hold   = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    ex_mem_bubble = 1'b0;
    next_state    = RUN;
    if (!rst_n) begin
      next_state = RUN;
    end else if (flush_req) begin
      // PC keeps writing: it loads the branch target.
      flush_if_id   = 1'b1;
      flush_id_ex   = 1'b1;
      ex_mem_bubble = 1'b1;
      next_state    = FLUSH;
    end else if (wait_req) begin
      pc_write      = 1'b0;
      if_id_hold    = 1'b1;
      id_ex_hold    = 1'b1;
      ex_mem_hold   = 1'b1;
      mem_wb_bubble = 1'b1;
      next_state    = MEM_WAIT;
    end else if (lu_go) begin
      pc_write      = 1'b0;
      if_id_hold    = 1'b1;
      id_ex_bubble  = 1'b1;
      next_state    = LOAD_STALL;
    end else begin
      next_state    = RUN;
    end
  end

  // State, saturating statistics, consecutive-wait counter and sticky timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RUN;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_r <= next_state;
      if (flush_req && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end else begin
        flush_cnt <= flush_cnt;
      end
      if ((wait_go || lu_go) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end else begin
        stall_cnt <= stall_cnt;
      end
      // wait_cnt counts frozen cycles; the freeze continues past the timeout.
      if (wait_go) begin
        if (wait_cnt != WAIT_SAT) begin
          wait_cnt <= wait_cnt + WAIT_ONE;
        end else begin
          wait_cnt <= wait_cnt;
        end
        if (wait_cnt >= WAIT_LAST) begin
          mem_timeout <= 1'b1;
        end else begin
          mem_timeout <= mem_timeout;
        end
      end else begin
        wait_cnt    <= '0;
        mem_timeout <= mem_timeout;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
// Directed scenarios followed by randomized stimulus, checked every cycle
// against a behavioural model of the hazard priority rules. A second DUT
// instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_hazard_stall_ctrl;

  localparam int MAX_WAIT = 8;

  logic         clk;
  logic         rst_n;
  logic [4:0]   id_rs;
  logic [4:0]   id_rt;
  logic         id_uses_rt;
  logic [158:0] id_ex_bus;
  logic [110:0] ex_mem_bus;
  logic         mem_taken;
  logic         dmem_busy;

  logic [8:0]   ctrl;
  logic [1:0]   state;
  logic [15:0]  stall_cnt;
  logic [15:0]  flush_cnt;
  logic         mem_timeout;

  logic [8:0]   ctrl_b;
  logic [1:0]   state_b;
  logic [1:0]   stall_cnt_b;
  logic [1:0]   flush_cnt_b;
  logic         mem_timeout_b;

  int n_checks;
  int n_errors;

  // Behavioural model state
  int m_state;
  int m_stall;
  int m_stall_s;
  int m_flush;
  int m_flush_s;
  int m_run;
  int m_to;

  hazard_stall_ctrl #(.CNT_W(16), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_ex_bus(id_ex_bus), .ex_mem_bus(ex_mem_bus), .mem_taken(mem_taken),
    .dmem_busy(dmem_busy),
    .pc_write(ctrl[8]), .if_id_hold(ctrl[7]), .id_ex_hold(ctrl[6]), .ex_mem_hold(ctrl[5]),
    .id_ex_bubble(ctrl[4]), .mem_wb_bubble(ctrl[3]), .flush_if_id(ctrl[2]),
    .flush_id_ex(ctrl[1]), .ex_mem_bubble(ctrl[0]),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
  );

  hazard_stall_ctrl #(.CNT_W(2), .MAX_WAIT(MAX_WAIT)) dut_small (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_ex_bus(id_ex_bus), .ex_mem_bus(ex_mem_bus), .mem_taken(mem_taken),
    .dmem_busy(dmem_busy),
    .pc_write(ctrl_b[8]), .if_id_hold(ctrl_b[7]), .id_ex_hold(ctrl_b[6]), .ex_mem_hold(ctrl_b[5]),
    .id_ex_bubble(ctrl_b[4]), .mem_wb_bubble(ctrl_b[3]), .flush_if_id(ctrl_b[2]),
    .flush_id_ex(ctrl_b[1]), .ex_mem_bubble(ctrl_b[0]),
    .state(state_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b), .mem_timeout(mem_timeout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    id_rs      = 5'd0;
    id_rt      = 5'd0;
    id_uses_rt = 1'b0;
    id_ex_bus  = '0;
    ex_mem_bus = '0;
    mem_taken  = 1'b0;
    dmem_busy  = 1'b0;
  endtask

  task automatic model_reset();
    m_state = 0; m_stall = 0; m_stall_s = 0; m_flush = 0; m_flush_s = 0;
    m_run = 0; m_to = 0;
  endtask

  // Called at a negedge with the inputs already applied: checks all outputs,
  // then advances the model across the next rising edge.
  task automatic run_cycle();
    bit fl, wt, lu;
    int rt;
    logic [8:0] exp;
    rt = int'(id_ex_bus[9:5]);
    fl = ex_mem_bus[106] && mem_taken;
    wt = dmem_busy && (ex_mem_bus[109] || ex_mem_bus[108]);
    lu = id_ex_bus[155] && (rt != 0) &&
         ((rt == int'(id_rs)) || (id_uses_rt && rt == int'(id_rt))) &&
         (m_state != 1) && (m_state != 2);
    if (fl)      exp = 9'b1_0000_0111;
    else if (wt) exp = 9'b0_1110_1000;
    else if (lu) exp = 9'b0_1001_0000;
    else         exp = 9'b1_0000_0000;
    #1;
    check_eq("ctrl", 32'(ctrl), 32'(exp));
    check_eq("ctrl_small", 32'(ctrl_b), 32'(exp));
    check_eq("state", 32'(state), m_state);
    check_eq("state_small", 32'(state_b), m_state);
    check_eq("stall_cnt", 32'(stall_cnt), m_stall);
    check_eq("stall_cnt_small", 32'(stall_cnt_b), m_stall_s);
    check_eq("flush_cnt", 32'(flush_cnt), m_flush);
    check_eq("flush_cnt_small", 32'(flush_cnt_b), m_flush_s);
    check_eq("mem_timeout", 32'(mem_timeout), m_to);
    check_eq("mem_timeout_small", 32'(mem_timeout_b), m_to);
    @(posedge clk);
    if (fl) begin
      m_state = 2;
      m_flush = (m_flush < 65535) ? m_flush + 1 : m_flush;
      m_flush_s = (m_flush_s < 3) ? m_flush_s + 1 : m_flush_s;
      m_run = 0;
    end else if (wt) begin
      m_state = 3;
      m_stall = (m_stall < 65535) ? m_stall + 1 : m_stall;
      m_stall_s = (m_stall_s < 3) ? m_stall_s + 1 : m_stall_s;
      m_run = m_run + 1;
      if (m_run >= MAX_WAIT) m_to = 1;
    end else if (lu) begin
      m_state = 1;
      m_stall = (m_stall < 65535) ? m_stall + 1 : m_stall;
      m_stall_s = (m_stall_s < 3) ? m_stall_s + 1 : m_stall_s;
      m_run = 0;
    end else begin
      m_state = 0;
      m_run = 0;
    end
    @(negedge clk);
  endtask

  // Assert reset away from any clock edge and check outputs immediately.
  task automatic reset_and_check();
    rst_n = 1'b0;
    #1;
    check_eq("rst_ctrl", 32'(ctrl), 32'h100);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check_eq("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    check_eq("rst_timeout", 32'(mem_timeout), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_stim();
    for (int i = 0; i < 159; i++) id_ex_bus[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 111; i++) ex_mem_bus[i] = 1'($urandom_range(0, 1));
    id_ex_bus[9:5]  = 5'($urandom_range(0, 4));
    id_rs           = 5'($urandom_range(0, 4));
    id_rt           = 5'($urandom_range(0, 4));
    id_uses_rt      = 1'($urandom_range(0, 1));
    ex_mem_bus[106] = ($urandom_range(0, 7) == 0);
    mem_taken       = 1'($urandom_range(0, 1));
    // Sticky busy produces longer wait runs.
    if (dmem_busy) dmem_busy = ($urandom_range(0, 9) != 0);
    else           dmem_busy = ($urandom_range(0, 5) == 0);
    if (dmem_busy) ex_mem_bus[108] = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    set_idle();
    rst_n = 1'b0;
    #1;
    check_eq("por_ctrl", 32'(ctrl), 32'h100);
    check_eq("por_state", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use stall on rs
    id_ex_bus[155] = 1'b1; id_ex_bus[9:5] = 5'd5; id_rs = 5'd5;
    run_cycle();
    check_eq("lu_state1", 32'(state), 32'd1);
    set_idle();
    run_cycle();
    check_eq("lu_state0", 32'(state), 32'd0);
    check_eq("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // rt=0 load and non-use rt match: no stall
    id_ex_bus[155] = 1'b1; id_ex_bus[9:5] = 5'd0; id_rs = 5'd0;
    run_cycle();
    id_ex_bus[9:5] = 5'd7; id_rs = 5'd1; id_rt = 5'd7; id_uses_rt = 1'b0;
    run_cycle();
    check_eq("nouse_stall_cnt", 32'(stall_cnt), 32'd1);

    // Branch flush with a simultaneous load-use, then lu suppressed in FLUSH
    set_idle();
    ex_mem_bus[106] = 1'b1; mem_taken = 1'b1;
    id_ex_bus[155] = 1'b1; id_ex_bus[9:5] = 5'd3; id_rs = 5'd3;
    run_cycle();
    check_eq("flush_cnt1", 32'(flush_cnt), 32'd1);
    ex_mem_bus[106] = 1'b0; mem_taken = 1'b0;
    run_cycle();
    check_eq("flush_lu_suppressed", 32'(stall_cnt), 32'd1);
    set_idle();
    run_cycle();

    // Memory wait: MemWrite with busy for 3 cycles
    ex_mem_bus[108] = 1'b1; dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle();
    check_eq("wait_state", 32'(state), 32'd3);
    dmem_busy = 1'b0;
    run_cycle();
    check_eq("wait_exit_state", 32'(state), 32'd0);
    check_eq("wait_stall_cnt", 32'(stall_cnt), 32'd4);

    // Timeout: busy held 10 cycles on a load
    set_idle();
    ex_mem_bus[109] = 1'b1; dmem_busy = 1'b1;
    for (int i = 0; i < 7; i++) run_cycle();
    check_eq("timeout_before", 32'(mem_timeout), 32'd0);
    run_cycle();
    check_eq("timeout_at8", 32'(mem_timeout), 32'd1);
    run_cycle();
    run_cycle();
    set_idle();
    for (int i = 0; i < 3; i++) run_cycle();
    check_eq("timeout_sticky", 32'(mem_timeout), 32'd1);
    check_eq("small_saturated", 32'(stall_cnt_b), 32'd3);

    // Reset in the middle of MEM_WAIT with the wait still requested
    ex_mem_bus[108] = 1'b1; dmem_busy = 1'b1;
    run_cycle();
    run_cycle();
    reset_and_check();
    set_idle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rand_stim();
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
